fpu_bus_master: RTL and testbench

FPU_BUS_MASTER -- requirements
Module: fpu_bus_master

---
 rtl/pa_fpu.sv | 44 ++++
 rtl/fpu_bus_strobe.sv | 56 +++++
 rtl/fpu_bus_master.sv | 199 +++++++++++++++++++
 tb/tb_fpu_bus_master.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pa_fpu.sv
// Shared definitions for the FPU bus master: controller states, FPU register
// map, operation codes and the canonical quiet NaN returned on abort.
package pa_fpu;

    typedef enum logic [3:0] {
        IDLE,
        WR_STB,
        WR_GAP,
        WAIT_END,
        RD_STB1,
        RD_STB2,
        RD_GAP,
        ACK,
        RESP
    } state_t;

    typedef enum logic {
        DIR_WRITE = 1'b0,
        DIR_READ  = 1'b1
    } dir_t;

    // FPU register map: operand A bytes, operand B bytes, opcode, result bytes
    localparam logic [5:0] OPA_BASE         = 6'd0;
    localparam logic [5:0] OPB_BASE         = 6'd4;
    localparam logic [5:0] OP_ADDR          = 6'd8;
    localparam logic [5:0] RES_BASE_DEFAULT = 6'h0C;

    // FPU operation codes
    localparam logic [7:0] OP_ADD  = 8'd0;
    localparam logic [7:0] OP_SUB  = 8'd1;
    localparam logic [7:0] OP_MUL  = 8'd2;
    localparam logic [7:0] OP_DIV  = 8'd3;
    localparam logic [7:0] OP_SQRT = 8'd4;

    localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;

    // Byte idx of the write frame {opcode, op_b, op_a}; idx 0 is op_a LSB.
    // The frame is contiguous, so byte idx lands at FPU address OPA_BASE+idx.
    function automatic logic [7:0] wr_byte(input logic [71:0] frame,
                                           input logic [3:0]  idx);
        return frame[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fpu_bus_strobe.sv
// Per-access strobe sequencer for the FPU bus. A write is one strobe cycle
// followed by one gap cycle; a read is two strobe cycles and one gap cycle.
// start is high on the first cycle of an access; done is high on its last.
module fpu_bus_strobe
    import pa_fpu::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  dir_t       dir,
    input  logic [5:0] addr_in,
    output logic [5:0] addr,
    output logic       cs,
    output logic       rd,
    output logic       wr,
    output logic       done
);

    logic       busy_reg;
    logic [1:0] phase_reg;
    logic       active;
    logic [1:0] cur_phase;
    logic       strobe;

    // Decode the strobes for the current phase of the access
    always_comb begin
        active    = start | busy_reg;
        cur_phase = start ? 2'd0 : phase_reg;
        if (dir == DIR_WRITE) begin
            strobe = active && (cur_phase == 2'd0);
            done   = active && (cur_phase == 2'd1);
        end else begin
            strobe = active && (cur_phase != 2'd2);
            done   = active && (cur_phase == 2'd2);
        end
        cs   = ~strobe;
        wr   = ~(strobe && (dir == DIR_WRITE));
        rd   = ~(strobe && (dir == DIR_READ));
        addr = active ? addr_in : 6'd0;
    end

    // Track the phase within the access in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_reg  <= 1'b0;
            phase_reg <= 2'd0;
        end else if (done) begin
            busy_reg  <= 1'b0;
            phase_reg <= 2'd0;
        end else if (active) begin
            busy_reg  <= 1'b1;
            phase_reg <= cur_phase + 2'd1;
        end
    end

endmodule

// File: rtl/fpu_bus_master.sv
// FPU bus master: takes one operation per request, writes both operands and
// the opcode to the FPU byte bus, waits for command end, reads the 32-bit
// result back and acknowledges the end of the command.
// Optional build macro FPU_MASTER_TIMEOUT_EN adds an abort counter while
// waiting for command end; on expiry the response carries a quiet NaN.
module fpu_bus_master
    import pa_fpu::*;
#(
    parameter logic [5:0] RES_BASE = RES_BASE_DEFAULT
`ifdef FPU_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 4096
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [7:0]  opcode,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] result,
    output logic        resp_timeout,
    output logic [7:0]  fpu_data_out,
    input  logic [7:0]  fpu_data_in,
    output logic [5:0]  fpu_addr,
    output logic        fpu_cs,
    output logic        fpu_rd,
    output logic        fpu_wr,
    output logic        fpu_end_ack,
    input  logic        fpu_cmd_end,
    input  logic        fpu_busy
);

    state_t      state_reg;
    state_t      state_next;
    logic [3:0]  idx_reg;
    logic [31:0] op_a_reg;
    logic [31:0] op_b_reg;
    logic [7:0]  opcode_reg;
    logic [31:0] result_reg;
    logic        strobe_start;
    logic        strobe_done;
    dir_t        dir;
    logic [5:0]  addr_sel;
    logic        timeout_hit;

`ifdef FPU_MASTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_reg;
    logic             timeout_reg;
    assign resp_timeout = timeout_reg;
`else
    assign resp_timeout = 1'b0;
`endif

    assign result = result_reg;

    fpu_bus_strobe u_strobe (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (strobe_start),
        .dir     (dir),
        .addr_in (addr_sel),
        .addr    (fpu_addr),
        .cs      (fpu_cs),
        .rd      (fpu_rd),
        .wr      (fpu_wr),
        .done    (strobe_done)
    );

    // Next-state logic and handshake/strobe controls
    always_comb begin
        state_next   = state_reg;
        strobe_start = 1'b0;
        dir          = DIR_WRITE;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        fpu_end_ack  = 1'b0;
        timeout_hit  = 1'b0;
        case (state_reg)
            IDLE: begin
                // rst_n gating keeps ready low while reset is held
                req_ready = rst_n && !fpu_busy;
                if (req_valid && req_ready) state_next = WR_STB;
            end
            WR_STB: begin
                strobe_start = 1'b1;
                state_next   = WR_GAP;
            end
            WR_GAP: begin
                if (strobe_done) state_next = (idx_reg == 4'd8) ? WAIT_END : WR_STB;
            end
            WAIT_END: begin
                if (fpu_cmd_end) begin
                    state_next = RD_STB1;
                end
`ifdef FPU_MASTER_TIMEOUT_EN
                else if (tmo_reg == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = RESP;
                end
`endif
            end
            RD_STB1: begin
                dir          = DIR_READ;
                strobe_start = 1'b1;
                state_next   = RD_STB2;
            end
            RD_STB2: begin
                dir        = DIR_READ;
                state_next = RD_GAP;
            end
            RD_GAP: begin
                dir = DIR_READ;
                if (strobe_done) state_next = (idx_reg == 4'd3) ? ACK : RD_STB1;
            end
            ACK: begin
                fpu_end_ack = 1'b1;
                if (!fpu_cmd_end) state_next = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address and write data for the access in progress
    always_comb begin
        addr_sel     = 6'd0;
        fpu_data_out = 8'h00;
        if (state_reg == WR_STB || state_reg == WR_GAP) begin
            addr_sel     = OPA_BASE + {2'b00, idx_reg};
            fpu_data_out = wr_byte({opcode_reg, op_b_reg, op_a_reg}, idx_reg);
        end else if (state_reg == RD_STB1 || state_reg == RD_STB2 || state_reg == RD_GAP) begin
            addr_sel = RES_BASE + {2'b00, idx_reg};
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Operand capture, byte index, result assembly and abort counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_reg    <= 4'd0;
            op_a_reg   <= 32'd0;
            op_b_reg   <= 32'd0;
            opcode_reg <= 8'd0;
            result_reg <= 32'd0;
`ifdef FPU_MASTER_TIMEOUT_EN
            tmo_reg     <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        op_a_reg   <= op_a;
                        op_b_reg   <= op_b;
                        opcode_reg <= opcode;
                        idx_reg    <= 4'd0;
`ifdef FPU_MASTER_TIMEOUT_EN
                        tmo_reg     <= '0;
                        timeout_reg <= 1'b0;
`endif
                    end
                end
                WR_GAP: begin
                    if (strobe_done) idx_reg <= (idx_reg == 4'd8) ? 4'd0 : idx_reg + 4'd1;
                end
                WAIT_END: begin
`ifdef FPU_MASTER_TIMEOUT_EN
                    tmo_reg <= tmo_reg + 1'b1;
                    if (timeout_hit) begin
                        result_reg  <= CANON_NAN;
                        timeout_reg <= 1'b1;
                    end
`endif
                end
                RD_STB2: begin
                    result_reg[{idx_reg[1:0], 3'b000} +: 8] <= fpu_data_in;
                end
                RD_GAP: begin
                    if (strobe_done) idx_reg <= (idx_reg == 4'd3) ? 4'd0 : idx_reg + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_bus_master.sv
// Testbench for fpu_bus_master with a behavioural FPU model. Expected bus
// writes and responses are queued when requests are issued and compared as
// the DUT produces them. Build with FPU_MASTER_TIMEOUT_EN to add the abort test.
module tb_fpu_bus_master;
    import pa_fpu::*;

    localparam logic [5:0] RB = 6'h0C;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [7:0]  opcode;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] result;
    logic        resp_timeout;
    logic [7:0]  fpu_data_out;
    logic [7:0]  fpu_data_in;
    logic [5:0]  fpu_addr;
    logic        fpu_cs;
    logic        fpu_rd;
    logic        fpu_wr;
    logic        fpu_end_ack;
    logic        fpu_cmd_end;
    logic        fpu_busy;

    int errors = 0;
    int checks = 0;

    logic [13:0] exp_wr_q[$];
    logic [32:0] exp_res_q[$];
    logic [31:0] model_result = 32'd0;
    bit          model_en = 1'b1;
    bit          ack_seen = 1'b0;
    bit          prev_wr_low = 1'b0;

`ifdef FPU_MASTER_TIMEOUT_EN
    fpu_bus_master #(.RES_BASE(RB), .TIMEOUT_CYCLES(16)) dut (
`else
    fpu_bus_master #(.RES_BASE(RB)) dut (
`endif
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .opcode       (opcode),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .result       (result),
        .resp_timeout (resp_timeout),
        .fpu_data_out (fpu_data_out),
        .fpu_data_in  (fpu_data_in),
        .fpu_addr     (fpu_addr),
        .fpu_cs       (fpu_cs),
        .fpu_rd       (fpu_rd),
        .fpu_wr       (fpu_wr),
        .fpu_end_ack  (fpu_end_ack),
        .fpu_cmd_end  (fpu_cmd_end),
        .fpu_busy     (fpu_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FPU result registers as seen on the read bus
    always_comb begin
        logic [5:0] off;
        off = fpu_addr - RB;
        case (off)
            6'd0:    fpu_data_in = model_result[7:0];
            6'd1:    fpu_data_in = model_result[15:8];
            6'd2:    fpu_data_in = model_result[23:16];
            6'd3:    fpu_data_in = model_result[31:24];
            default: fpu_data_in = 8'h00;
        endcase
    end

    // Bus monitor: protocol rules and write scoreboard
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checks++;
                if ((!fpu_wr && !fpu_rd) || (fpu_cs && (!fpu_wr || !fpu_rd))) begin
                    errors++;
                    $display("FAIL strobe_rule: cs=%b rd=%b wr=%b required wr/rd not both low and cs=1 -> wr=rd=1",
                             fpu_cs, fpu_rd, fpu_wr);
                end
                if (!fpu_cs && !fpu_wr) begin
                    checks++;
                    if (prev_wr_low) begin
                        errors++;
                        $display("FAIL wr_strobe_len: wr low for 2+ cycles, required exactly 1");
                    end
                    checks++;
                    if (exp_wr_q.size() == 0) begin
                        errors++;
                        $display("FAIL write_unexpected: addr=%h data=%h required no write", fpu_addr, fpu_data_out);
                    end else begin
                        logic [13:0] e;
                        e = exp_wr_q.pop_front();
                        if ({fpu_addr, fpu_data_out} !== e) begin
                            errors++;
                            $display("FAIL write: addr=%h data=%h required addr=%h data=%h",
                                     fpu_addr, fpu_data_out, e[13:8], e[7:0]);
                        end else begin
                            $display("write addr=%h data=%h", fpu_addr, fpu_data_out);
                        end
                    end
                end
                if (fpu_end_ack) ack_seen = 1'b1;
            end
            prev_wr_low = rst_n && !fpu_wr;
        end
    end

    // FPU command model: raise cmd_end shortly after the opcode write,
    // drop it once the master acknowledges
    initial begin
        forever begin
            @(negedge clk);
            if (model_en && rst_n && !fpu_cs && !fpu_wr && fpu_addr == OP_ADDR) begin
                repeat (3) @(negedge clk);
                fpu_cmd_end = 1'b1;
                for (int i = 0; i < 200 && !fpu_end_ack; i++) @(negedge clk);
                repeat (2) @(negedge clk);
                fpu_cmd_end = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Queue the expected bus writes/response and perform the request handshake;
    // returns at the negedge of the first write strobe cycle
    task automatic send_req(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                            input logic [31:0] mres, input logic etmo, input logic [31:0] eres,
                            output bit ok);
        logic [71:0] frame;
        frame = {op, b, a};
        for (int i = 0; i < 9; i++) exp_wr_q.push_back({6'(i), frame[i*8 +: 8]});
        exp_res_q.push_back({etmo, eres});
        model_result = mres;
        @(negedge clk);
        op_a = a;
        op_b = b;
        opcode = op;
        req_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Wait for a response, optionally stall it, then accept it
    task automatic collect_resp(input int hold, output logic [31:0] got, output logic got_tmo,
                                output bit ok, output bit stable, output bit dropped);
        ok = 1'b0;
        stable = 1'b1;
        dropped = 1'b0;
        got = 32'd0;
        got_tmo = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (resp_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            got = result;
            got_tmo = resp_timeout;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (!resp_valid || result !== got || req_ready) stable = 1'b0;
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            dropped = !resp_valid;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, result, resp_timeout, fpu_cs, fpu_rd, fpu_wr,
             fpu_end_ack, fpu_addr, fpu_data_out} !== {1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1,
                                                      1'b0, 6'd0, 8'd0}) begin
            errors++;
            $display("FAIL reset_values: rdy=%b rv=%b res=%h tmo=%b cs=%b rd=%b wr=%b ack=%b addr=%h d=%h required 0,0,0,0,1,1,1,0,0,0",
                     req_ready, resp_valid, result, resp_timeout, fpu_cs, fpu_rd, fpu_wr,
                     fpu_end_ack, fpu_addr, fpu_data_out);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset: req_ready=%b required 1", req_ready);
        end
        $display("reset done");
    endtask

    task automatic test_basic();
        bit ok, stable, dropped;
        logic [31:0] got;
        logic got_tmo;
        logic [32:0] e;
        send_req(32'h4331E148, 32'h42C7FAE1, OP_DIV, 32'h3FE3B58C, 1'b0, 32'h3FE3B58C, ok);
        checks++;
        if (!ok || fpu_cs !== 1'b0 || fpu_wr !== 1'b0 || fpu_addr !== 6'd0) begin
            errors++;
            $display("FAIL first_wr_stb: ok=%b cs=%b wr=%b addr=%h required 1,0,0,00", ok, fpu_cs, fpu_wr, fpu_addr);
        end
        collect_resp(0, got, got_tmo, ok, stable, dropped);
        e = exp_res_q.pop_front();
        checks++;
        if (!ok || {got_tmo, got} !== e || !dropped) begin
            errors++;
            $display("FAIL basic_resp: ok=%b result=%h tmo=%b dropped=%b required result=%h tmo=%b", ok, got, got_tmo, dropped, e[31:0], e[32]);
        end
        $display("basic txn result=%h tmo=%b", got, got_tmo);
    endtask

    task automatic test_backpressure();
        bit ok, stable, dropped;
        logic [31:0] got;
        logic got_tmo;
        logic [32:0] e;
        send_req(32'h449A522C, 32'h458EBF1F, OP_DIV, 32'h3E8A60F3, 1'b0, 32'h3E8A60F3, ok);
        checks++;
        if (!ok || fpu_cs !== 1'b0 || fpu_wr !== 1'b0) begin
            errors++;
            $display("FAIL first_wr_stb2: ok=%b cs=%b wr=%b required 1,0,0", ok, fpu_cs, fpu_wr);
        end
        collect_resp(10, got, got_tmo, ok, stable, dropped);
        e = exp_res_q.pop_front();
        checks++;
        if (!ok || {got_tmo, got} !== e) begin
            errors++;
            $display("FAIL bp_resp: ok=%b result=%h tmo=%b required result=%h tmo=%b", ok, got, got_tmo, e[31:0], e[32]);
        end
        checks++;
        if (!stable || !dropped) begin
            errors++;
            $display("FAIL bp_stall: stable=%b dropped=%b required 1,1", stable, dropped);
        end
        $display("backpressure txn result=%h stable=%b", got, stable);
    endtask

    task automatic test_busy();
        bit ok, stable, dropped, quiet;
        logic [31:0] got;
        logic got_tmo;
        logic [32:0] e;
        @(negedge clk);
        fpu_busy = 1'b1;
        fpu_cmd_end = 1'b1;
        op_a = 32'h3F800000;
        op_b = 32'h40000000;
        opcode = OP_ADD;
        req_valid = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (req_ready !== 1'b0 || fpu_cs !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++;
            $display("FAIL busy_block: req_ready/cs activity while busy, required rdy=0 cs=1");
        end
        fpu_busy = 1'b0;
        fpu_cmd_end = 1'b0;
        send_req(32'h3F800000, 32'h40000000, OP_ADD, 32'h40400000, 1'b0, 32'h40400000, ok);
        collect_resp(0, got, got_tmo, ok, stable, dropped);
        e = exp_res_q.pop_front();
        checks++;
        if (!ok || {got_tmo, got} !== e) begin
            errors++;
            $display("FAIL busy_resp: ok=%b result=%h required %h", ok, got, e[31:0]);
        end
        $display("busy txn result=%h", got);
    endtask

    task automatic test_back_to_back();
        bit ok, stable, dropped;
        logic [31:0] got;
        logic got_tmo;
        logic [32:0] e;
        for (int t = 0; t < 3; t++) begin
            logic [31:0] a, b, r;
            a = $urandom;
            b = $urandom;
            r = $urandom;
            send_req(a, b, OP_MUL, r, 1'b0, r, ok);
            collect_resp(t, got, got_tmo, ok, stable, dropped);
            e = exp_res_q.pop_front();
            checks++;
            if (!ok || {got_tmo, got} !== e || !stable || !dropped) begin
                errors++;
                $display("FAIL b2b_resp%0d: ok=%b result=%h tmo=%b required result=%h tmo=%b", t, ok, got, got_tmo, e[31:0], e[32]);
            end
            $display("b2b txn %0d a=%h b=%h result=%h", t, a, b, got);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int n;
        send_req(32'h11223344, 32'h55667788, OP_SUB, 32'h0, 1'b0, 32'h0, ok);
        n = 1;
        for (int i = 0; i < 40 && n < 5; i++) begin
            @(negedge clk);
            if (!fpu_cs && !fpu_wr) n++;
        end
        checks++;
        if (n != 5 || fpu_addr !== 6'd4) begin
            errors++;
            $display("FAIL mid_reach: strobes=%0d addr=%h required 5, 04", n, fpu_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (fpu_cs !== 1'b1 || fpu_wr !== 1'b1 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: cs=%b wr=%b rv=%b rdy=%b required 1,1,0,0", fpu_cs, fpu_wr, resp_valid, req_ready);
        end
        exp_wr_q.delete();
        exp_res_q.delete();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || fpu_cs !== 1'b1) begin
            errors++;
            $display("FAIL mid_idle: rdy=%b cs=%b required 1,1", req_ready, fpu_cs);
        end
        $display("mid-access reset done");
    endtask

`ifdef FPU_MASTER_TIMEOUT_EN
    task automatic test_timeout();
        bit ok, found, stable, dropped;
        logic [31:0] got;
        logic got_tmo;
        logic [32:0] e;
        int n;
        model_en = 1'b0;
        ack_seen = 1'b0;
        send_req(32'h40490FDB, 32'h3F800000, OP_DIV, 32'h12345678, 1'b1, CANON_NAN, ok);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (!fpu_cs && !fpu_wr && fpu_addr == OP_ADDR) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n = 0;
        while (found && !resp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!found || n != 18) begin
            errors++;
            $display("FAIL tmo_latency: found=%b cycles=%0d required 1, 18", found, n);
        end
        collect_resp(0, got, got_tmo, ok, stable, dropped);
        e = exp_res_q.pop_front();
        checks++;
        if (!ok || {got_tmo, got} !== e) begin
            errors++;
            $display("FAIL tmo_resp: result=%h tmo=%b required %h %b", got, got_tmo, e[31:0], e[32]);
        end
        checks++;
        if (ack_seen) begin
            errors++;
            $display("FAIL tmo_no_ack: end_ack pulsed=1 required 0");
        end
        model_en = 1'b1;
        $display("timeout txn result=%h tmo=%b", got, got_tmo);
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        resp_ready = 1'b0;
        op_a = 32'd0;
        op_b = 32'd0;
        opcode = 8'd0;
        fpu_cmd_end = 1'b0;
        fpu_busy = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_busy();
        test_back_to_back();
        test_reset_mid();
`ifdef FPU_MASTER_TIMEOUT_EN
        test_timeout();
`endif
        test_basic();
        checks++;
        if (exp_wr_q.size() != 0 || exp_res_q.size() != 0) begin
            errors++;
            $display("FAIL drain: writes left=%0d resps left=%0d required 0,0", exp_wr_q.size(), exp_res_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
